// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: default geometry,
// refill FSM encoding and address-field width helpers.
package icache_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_INDEX_BITS  = 6;
    localparam int DEF_OFFSET_BITS = 2;
    localparam int DEF_WAYS        = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Tag width left over after the byte, word-in-line and index fields.
    function automatic int tag_width(input int addr_width, input int index_bits,
                                     input int offset_bits);
        return addr_width - index_bits - offset_bits - 2;
    endfunction

    // Victim pointer storage width; a direct-mapped cache keeps one constant-zero bit.
    function automatic int victim_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and line data, with a
// combinational lookup port and a refill/invalidate write port.
module icache_way
    import icache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int TAG_BITS    = tag_width(DEF_ADDR_WIDTH, DEF_INDEX_BITS, DEF_OFFSET_BITS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [TAG_BITS-1:0]    rd_tag,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   hit,
    output logic [31:0]            rd_data,
    input  logic                   wr_word,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [31:0]            wr_data,
    input  logic                   fill,
    input  logic [TAG_BITS-1:0]    fill_tag,
    input  logic                   line_clear,
    input  logic                   clear_all
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;

    logic                valid_r [SETS];
    logic [TAG_BITS-1:0] tag_r   [SETS];
    logic [31:0]         data_r  [SETS*WORDS];

    assign hit     = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);
    assign rd_data = data_r[{rd_index, rd_offset}];

    // Valid bits: a full clear wins over a same-cycle line fill.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= 1'b0;
            end
        end else if (fill) begin
            valid_r[wr_index] <= 1'b1;
        end else if (line_clear) begin
            valid_r[wr_index] <= 1'b0;
        end
    end

    // Tag store, written once the last word of a line has arrived.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_r[wr_index] <= fill_tag;
        end
    end

    // Line data, written one word per returned memory beat.
    always_ff @(posedge clk) begin
        if (wr_word) begin
            data_r[{wr_index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: lookup and hit mux, round-robin victim choice,
// and the burst refill FSM towards the memory controller.
module icache_sa
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int WAYS        = DEF_WAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_IF_valid,
    output logic [31:0]           instr_IF,
    input  logic                  jump_wrong,
    input  logic                  invalidate,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_data,
    output logic                  busy
);
    localparam int TAG_BITS  = tag_width(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
    localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int VW        = victim_width(WAYS);

    logic [TAG_BITS-1:0]    pc_tag_s;
    logic [INDEX_BITS-1:0]  pc_index_s;
    logic [OFFSET_BITS-1:0] pc_offset_s;
    logic                   unused_pc_s;

    state_t                 state_r;
    logic [LINE_BITS-1:0]   line_r;
    logic [VW-1:0]          victim_r;
    logic [OFFSET_BITS-1:0] cnt_r;
    logic [VW-1:0]          vptr_r [SETS];
    logic                   instr_valid_r;
    logic [31:0]            instr_r;

    logic [INDEX_BITS-1:0]  line_idx_s;
    logic [TAG_BITS-1:0]    line_tag_s;
    logic [INDEX_BITS-1:0]  wr_index_s;
    logic                   act_s;
    logic                   refill_s;
    logic                   abort_s;
    logic                   word_wr_s;
    logic                   last_s;
    logic                   miss_s;
    logic                   clear_all_s;
    logic                   hit_s   [WAYS];
    logic [31:0]            rdata_s [WAYS];
    logic                   hit_any_s;
    logic [31:0]            hit_data_s;

    assign pc_tag_s    = pc[ADDR_WIDTH-1 -: TAG_BITS];
    assign pc_index_s  = pc[2+OFFSET_BITS +: INDEX_BITS];
    assign pc_offset_s = pc[2 +: OFFSET_BITS];
    assign unused_pc_s = ^pc[1:0];

    assign line_idx_s  = line_r[INDEX_BITS-1:0];
    assign line_tag_s  = line_r[LINE_BITS-1 -: TAG_BITS];

    // Refill writes target the latched line; the entry clear targets the missing pc.
    assign wr_index_s  = refill_s ? line_idx_s : pc_index_s;

    assign act_s       = rdy && !rst;
    assign refill_s    = (state_r == REFILL);
    assign abort_s     = jump_wrong || invalidate;
    assign word_wr_s   = act_s && refill_s && !abort_s && mem_valid;
    assign last_s      = word_wr_s && (&cnt_r);
    assign miss_s      = act_s && !refill_s && !abort_s && !hit_any_s;
    assign clear_all_s = act_s && invalidate;

    assign mem_req        = refill_s && !jump_wrong;
    assign mem_addr       = {line_r, cnt_r, 2'b00};
    assign busy           = refill_s;
    assign instr_IF_valid = instr_valid_r;
    assign instr_IF       = instr_r;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic sel_s;
        logic new_s;

        assign sel_s = (victim_r == VW'(g));
        assign new_s = (vptr_r[pc_index_s] == VW'(g));

        icache_way #(
            .INDEX_BITS  (INDEX_BITS),
            .OFFSET_BITS (OFFSET_BITS),
            .TAG_BITS    (TAG_BITS)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .rd_index   (pc_index_s),
            .rd_tag     (pc_tag_s),
            .rd_offset  (pc_offset_s),
            .hit        (hit_s[g]),
            .rd_data    (rdata_s[g]),
            .wr_word    (word_wr_s && sel_s),
            .wr_index   (wr_index_s),
            .wr_offset  (cnt_r),
            .wr_data    (mem_data),
            .fill       (last_s && sel_s),
            .fill_tag   (line_tag_s),
            .line_clear (miss_s && new_s),
            .clear_all  (clear_all_s)
        );
    end

    // Hit mux: at most one way matches, so OR-combining the way outputs is exact.
    always_comb begin
        hit_any_s  = 1'b0;
        hit_data_s = 32'h0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_s[w]) begin
                hit_any_s  = 1'b1;
                hit_data_s = hit_data_s | rdata_s[w];
            end else begin
                hit_data_s = hit_data_s;
            end
        end
    end

    // Refill FSM, round-robin victim pointers and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            line_r        <= '0;
            victim_r      <= '0;
            cnt_r         <= '0;
            instr_valid_r <= 1'b0;
            instr_r       <= 32'h0;
            for (int s = 0; s < SETS; s++) begin
                vptr_r[s] <= '0;
            end
        end else if (rdy) begin
            case (state_r)
                IDLE: begin
                    if (abort_s) begin
                        instr_valid_r <= 1'b0;
                    end else if (hit_any_s) begin
                        instr_valid_r <= 1'b1;
                        instr_r       <= hit_data_s;
                    end else begin
                        instr_valid_r <= 1'b0;
                        line_r        <= {pc_tag_s, pc_index_s};
                        victim_r      <= vptr_r[pc_index_s];
                        cnt_r         <= '0;
                        state_r       <= REFILL;
                    end
                end
                REFILL: begin
                    instr_valid_r <= 1'b0;
                    if (abort_s) begin
                        state_r <= IDLE;
                    end else if (mem_valid) begin
                        cnt_r <= cnt_r + OFFSET_BITS'(1);
                        if (&cnt_r) begin
                            state_r <= IDLE;
                            vptr_r[line_idx_s] <= (WAYS > 1) ? vptr_r[line_idx_s] + VW'(1) : VW'(0);
                        end
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa: expected fetch results and refill addresses are
// queued as stimulus is applied and compared when the cache produces them.
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc;
    logic        instr_IF_valid;
    logic [31:0] instr_IF;
    logic        jump_wrong;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        busy;

    typedef struct {
        bit          v;
        logic [31:0] d;
    } fexp_t;

    fexp_t       fq  [$];
    logic [31:0] maq [$];
    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  salt = 8'h00;
    bit          mem_on = 1'b1;

    icache_sa dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .pc             (pc),
        .instr_IF_valid (instr_IF_valid),
        .instr_IF       (instr_IF),
        .jump_wrong     (jump_wrong),
        .invalidate     (invalidate),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_data       (mem_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (32'hA0 + ((a - 32'h100) >> 2)) ^ {salt, 24'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // One clock: memory model answers before the edge, fetch scoreboard pops after it.
    task automatic tick();
        fexp_t e;
        #1;
        if (mem_on && rdy && mem_req) begin
            mem_valid = 1'b1;
            mem_data  = mem_fn(mem_addr);
            if (maq.size() > 0) chk("mem_addr", mem_addr, maq.pop_front());
            else chk("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
        end else begin
            mem_valid = 1'b0;
            mem_data  = 32'h0;
        end
        @(posedge clk);
        #1;
        if (fq.size() > 0) begin
            e = fq.pop_front();
            chk("if_valid", {31'h0, instr_IF_valid}, {31'h0, e.v});
            if (e.v) chk("if_data", instr_IF, e.d);
        end
        @(negedge clk);
    endtask

    task automatic expect_miss(input logic [31:0] a);
        pc = a;
        fq.push_back('{1'b0, 32'h0});
    endtask

    task automatic fetch(input logic [31:0] a);
        pc = a;
        fq.push_back('{1'b1, mem_fn(a)});
        tick();
    endtask

    // Full miss-and-refill of the line holding a; expects exactly 4 data cycles.
    task automatic miss_fill(input logic [31:0] a);
        int n;
        expect_miss(a);
        for (int w = 0; w < 4; w++) maq.push_back((a & 32'hFFFF_FFF0) + 32'(4 * w));
        tick();
        n = 0;
        while (busy && n < 20) begin
            chk("refill_ifv", {31'h0, instr_IF_valid}, 32'h0);
            tick();
            n++;
        end
        chk("refill_len", n, 4);
        chk("refill_q", maq.size(), 0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; pc = 32'h0; jump_wrong = 1'b0; invalidate = 1'b0;
        mem_valid = 1'b0; mem_data = 32'h0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ifv", {31'h0, instr_IF_valid}, 32'h0);
        chk("rst_instr", instr_IF, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);

        // Cold miss then offset hits
        miss_fill(32'h100);
        fetch(32'h108);
        fetch(32'h100);
        fetch(32'h10C);

        // Two ways share index 0x10; a third line evicts way 0
        miss_fill(32'h1100);
        fetch(32'h1104);
        fetch(32'h100);
        miss_fill(32'h2100);
        fetch(32'h2100);
        fetch(32'h1100);
        miss_fill(32'h100);
        fetch(32'h10C);

        // Mispredict abort after two words
        expect_miss(32'h200);
        maq.push_back(32'h200);
        maq.push_back(32'h204);
        tick();
        tick();
        tick();
        jump_wrong = 1'b1;
        #1;
        chk("abort_req", {31'h0, mem_req}, 32'h0);
        fq.push_back('{1'b0, 32'h0});
        tick();
        jump_wrong = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        miss_fill(32'h200);
        fetch(32'h208);

        // fence.i drops everything; refill sees new memory contents
        pc = 32'h208;
        invalidate = 1'b1;
        fq.push_back('{1'b0, 32'h0});
        tick();
        invalidate = 1'b0;
        salt = 8'h05;
        miss_fill(32'h104);
        fetch(32'h104);

        // Three-cycle rdy stall mid-refill
        expect_miss(32'h300);
        for (int w = 0; w < 4; w++) maq.push_back(32'h300 + 32'(4 * w));
        tick();
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", mem_addr, 32'h304);
            chk("stall_busy", {31'h0, busy}, 32'h1);
            chk("stall_req", {31'h0, mem_req}, 32'h1);
            chk("stall_ifv", {31'h0, instr_IF_valid}, 32'h0);
        end
        rdy = 1'b1;
        begin
            int n = 0;
            while (busy && n < 20) begin
                tick();
                n++;
            end
            chk("stall_rest", n, 3);
        end
        fetch(32'h30C);

        // Reset in the middle of a refill
        expect_miss(32'h400);
        maq.push_back(32'h400);
        maq.push_back(32'h404);
        tick();
        tick();
        tick();
        mem_on = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_on = 1'b1;
        chk("rrst_busy", {31'h0, busy}, 32'h0);
        chk("rrst_req", {31'h0, mem_req}, 32'h0);
        miss_fill(32'h400);
        fetch(32'h404);

        // Mispredict in IDLE suppresses a hit
        pc = 32'h404;
        jump_wrong = 1'b1;
        fq.push_back('{1'b0, 32'h0});
        tick();
        jump_wrong = 1'b0;
        fetch(32'h404);

        chk("fq_left", fq.size(), 0);
        chk("maq_left", maq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
